// File: rtl/instr_encoder.sv
// instr_encoder: encodes symbolic MIPS instructions into 32-bit words, buffers
// them in a small FIFO, and writes them sequentially into instruction memory.
//
// Optional build macro: INSTR_ENC_DELAY_SLOT_EN
//   defined   -> every legal BEQ/J is followed by a NOP pushed at the same edge;
//                in_ready requires at least two free entries
//   undefined -> no padding; in_ready requires one free entry
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     request handshake
//   in_cls, in_op           instruction class and R-type operation
//   in_rs/rt/rd/shamt       register and shift fields
//   in_imm, in_target       immediate/offset and jump target
//   addr_load, addr_base    reload the write address
//   mem_we/addr/wdata/ack   instruction memory write port with ack backpressure
//   err                     one-cycle pulse when an illegal request is dropped
//   words_written           saturating count of acknowledged writes
module instr_encoder #(
  parameter int unsigned   DEPTH      = 4,
  parameter int unsigned   AW         = 32,
  parameter logic [AW-1:0] ADDR_RESET = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_cls,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [2:0]    in_op,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          addr_load,
  input  logic [AW-1:0] addr_base,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  output logic          err,
  output logic [15:0]   words_written
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
`ifdef INSTR_ENC_DELAY_SLOT_EN
  localparam int unsigned NEED = 2;
`else
  localparam int unsigned NEED = 1;
`endif
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NEED_C  = CW'(NEED);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_n;
  logic [CW-1:0] count_q, count_n, remain, n_push;

  logic [31:0]   enc_word, head_n;
  logic [5:0]    funct;
  logic          legal;
`ifdef INSTR_ENC_DELAY_SLOT_EN
  logic          is_br;
`endif
  logic          accept, push1, push2, pop, ready_n;
  logic [AW-1:0] addr_n;
  logic [15:0]   words_n;

  // Field encoder: builds the instruction word and flags illegal requests.
  always_comb begin
    funct    = 6'b000000;
    enc_word = '0;
    legal    = 1'b1;
`ifdef INSTR_ENC_DELAY_SLOT_EN
    is_br    = 1'b0;
`endif
    case (in_op)
      3'd0:    funct = 6'b100000;
      3'd1:    funct = 6'b100010;
      3'd2:    funct = 6'b100100;
      3'd3:    funct = 6'b100101;
      3'd4:    funct = 6'b101010;
      default: funct = 6'b000000;
    endcase
    case (in_cls)
      3'd0: begin
        enc_word = {OP_R, in_rs, in_rt, in_rd, in_shamt, funct};
        legal    = (in_op <= 3'd4);
      end
      3'd1: enc_word = {OP_ORI, in_rs, in_rt, in_imm};
      3'd2: enc_word = {OP_LW,  in_rs, in_rt, in_imm};
      3'd3: enc_word = {OP_SW,  in_rs, in_rt, in_imm};
      3'd4: begin
        enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
`ifdef INSTR_ENC_DELAY_SLOT_EN
        is_br    = 1'b1;
`endif
      end
      3'd5: begin
        enc_word = {OP_J, in_target};
`ifdef INSTR_ENC_DELAY_SLOT_EN
        is_br    = 1'b1;
`endif
      end
      default: legal = 1'b0;
    endcase
  end

  // Next-state for FIFO occupancy, registered outputs and address counter.
  always_comb begin
    accept = in_valid && in_ready;
    push1  = accept && legal;
`ifdef INSTR_ENC_DELAY_SLOT_EN
    push2  = push1 && is_br;
`else
    push2  = 1'b0;
`endif
    pop      = mem_we && mem_ack;
    n_push   = CW'(push1) + CW'(push2);
    count_n  = count_q + n_push - CW'(pop);
    remain   = count_q - CW'(pop);
    rd_ptr_n = rd_ptr_q + PW'(pop);
    // Head after the edge: an older entry if one survives the pop, else the
    // first word pushed now (a branch precedes its NOP).
    head_n = '0;
    if (remain != '0) begin
      head_n = fifo_q[rd_ptr_n];
    end else if (push1) begin
      head_n = enc_word;
    end
    ready_n = (DEPTH_C - count_n) >= NEED_C;
    // A load wins over the increment; the popped word already used the old address.
    addr_n = mem_addr;
    if (addr_load) begin
      addr_n = addr_base;
    end else if (pop) begin
      addr_n = mem_addr + AW'(4);
    end
    words_n = words_written;
    if (pop && (words_written != 16'hFFFF)) begin
      words_n = words_written + 16'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      mem_addr      <= ADDR_RESET;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      if (push1) begin
        fifo_q[wr_ptr_q] <= enc_word;
      end
      if (push2) begin
        fifo_q[PW'(wr_ptr_q + PW'(1))] <= '0;
      end
      wr_ptr_q      <= wr_ptr_q + PW'(n_push);
      rd_ptr_q      <= rd_ptr_n;
      count_q       <= count_n;
      in_ready      <= ready_n;
      mem_we        <= (count_n != '0);
      mem_wdata     <= head_n;
      mem_addr      <= addr_n;
      err           <= accept && !legal;
      words_written <= words_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vectors, a queue-based cycle model of
// the loader, and literal expectations for the documented encodings.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
`ifdef INSTR_ENC_DELAY_SLOT_EN
  localparam int NEED  = 2;
  localparam int NFILL = DEPTH - 1;
  localparam int N2    = 4;
  localparam int NBEQ  = 2;
`else
  localparam int NEED  = 1;
  localparam int NFILL = DEPTH;
  localparam int N2    = 3;
  localparam int NBEQ  = 1;
`endif

  logic          clk, rst_n, in_valid, in_ready;
  logic [2:0]    in_cls, in_op;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          addr_load;
  logic [AW-1:0] addr_base;
  logic          mem_we, mem_ack, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [15:0]   words_written;

  instr_encoder #(.DEPTH(DEPTH), .AW(AW), .ADDR_RESET(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_op(in_op), .in_imm(in_imm), .in_target(in_target),
    .addr_load(addr_load), .addr_base(addr_base), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .err(err), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference encoding from opcode/funct numbers and field bit positions.
  function automatic void model_enc(input logic [2:0] cls, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [4:0] sh, input logic [2:0] op,
                                    input logic [15:0] imm, input logic [25:0] tgt,
                                    output logic [31:0] w, output bit lg, output bit br);
    logic [31:0] ft [0:4];
    ft = '{32'd32, 32'd34, 32'd36, 32'd37, 32'd42};
    w  = '0;
    lg = 1'b1;
    br = 1'b0;
    case (cls)
      3'd0: begin
        if (op <= 3'd4)
          w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | ft[op];
        else
          lg = 1'b0;
      end
      3'd1: w = (32'd13 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      3'd2: w = (32'd35 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      3'd3: w = (32'd43 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      3'd4: begin w = (32'd4 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm); br = 1'b1; end
      3'd5: begin w = (32'd2 << 26) | 32'(tgt); br = 1'b1; end
      default: lg = 1'b0;
    endcase
  endfunction

  // Cycle model: a queue of pending words plus address/count/err/ready state.
  logic [31:0]   mq [$];
  logic [AW-1:0] maddr;
  int            mwords;
  bit            merr, mready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      maddr  = '0;
      mwords = 0;
      merr   = 1'b0;
      mready = 1'b0;
    end else begin
      logic [31:0] w;
      bit lg, br, pop, acc;
      pop = (mq.size() > 0) && mem_ack;
      acc = in_valid && mready;
      model_enc(in_cls, in_rs, in_rt, in_rd, in_shamt, in_op, in_imm, in_target, w, lg, br);
      if (pop) begin
        void'(mq.pop_front());
        if (mwords < 65535) mwords++;
      end
      if (addr_load) maddr = addr_base;
      else if (pop)  maddr = maddr + 32'd4;
      merr = acc && !lg;
      if (acc && lg) begin
        mq.push_back(w);
`ifdef INSTR_ENC_DELAY_SLOT_EN
        if (br) mq.push_back(32'h0);
`endif
      end
      mready = (int'(DEPTH) - mq.size()) >= NEED;
    end
  end

  // Compare DUT against the model every cycle, shortly after the edge.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(mready));
      check("mem_we", 32'(mem_we), 32'(mq.size() > 0));
      check("mem_addr", mem_addr, maddr);
      if (mq.size() > 0) check("mem_wdata", mem_wdata, mq[0]);
      check("err", 32'(err), 32'(merr));
      check("words_written", 32'(words_written), 32'(mwords));
    end
  end

  // Log of completed writes: {addr, data}.
  logic [63:0] wlog [$];
  always @(posedge clk) begin
    if (rst_n && mem_we && mem_ack) wlog.push_back({mem_addr, mem_wdata});
  end

  task automatic send(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [2:0] op, input logic [15:0] imm,
                      input logic [25:0] tgt);
    int t;
    @(negedge clk);
    in_cls = cls; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = 5'd0;
    in_op = op; in_imm = imm; in_target = tgt; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for cls %0d", cls);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  logic [63:0] e;
  logic [31:0] sw_exp [0:3];
  int          w0;
  logic [31:0] a3;

  initial begin
    sw_exp = '{32'hAC220010, 32'hAC430020, 32'hAC640030, 32'hAC850040};
    rst_n = 1'b0; in_valid = 1'b0; in_cls = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_op = '0; in_imm = '0; in_target = '0; addr_load = 1'b0;
    addr_base = '0; mem_ack = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_words", 32'(words_written), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'h1);

    // ADD r3 = r1 + r2, one-cycle latency
    send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 16'h0, 26'h0);
    @(negedge clk);
    check("add_we", 32'(mem_we), 32'h1);
    check("add_addr", mem_addr, 32'h0);
    check("add_wdata", mem_wdata, 32'h00221820);
    @(negedge clk);
    check("add_we_after", 32'(mem_we), 32'h0);
    check("add_words", 32'(words_written), 32'h1);

    // Address reload then ORI, LW, J
    @(negedge clk) begin addr_load = 1'b1; addr_base = 32'h100; end
    @(negedge clk) addr_load = 1'b0;
    wlog.delete();
    send(3'd1, 5'd0, 5'd5, 5'd0, 3'd0, 16'h00FF, 26'h0);
    send(3'd2, 5'd29, 5'd8, 5'd0, 3'd0, 16'hFFFC, 26'h0);
    send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 16'h0, 26'h0000040);
    repeat (4) @(negedge clk);
    check("seq_count", 32'(wlog.size()), 32'(N2));
    if (wlog.size() >= 3) begin
      e = wlog[0]; check("ori_addr", e[63:32], 32'h100); check("ori_data", e[31:0], 32'h340500FF);
      e = wlog[1]; check("lw_addr", e[63:32], 32'h104);  check("lw_data", e[31:0], 32'h8FA8FFFC);
      e = wlog[2]; check("j_addr", e[63:32], 32'h108);   check("j_data", e[31:0], 32'h08000040);
    end
    a3 = 32'h100 + 32'(4 * N2);

    // Backpressure: fill the FIFO with SW words while ack is low
    @(negedge clk) mem_ack = 1'b0;
    wlog.delete();
    for (int i = 0; i < NFILL; i++)
      send(3'd3, 5'(i + 1), 5'(i + 2), 5'd0, 3'd0, 16'(16 * (i + 1)), 26'h0);
    repeat (2) @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_we", 32'(mem_we), 32'h1);
    check("full_head", mem_wdata, 32'hAC220010);
    check("full_addr", mem_addr, a3);
    mem_ack = 1'b1;
    repeat (NFILL + 3) @(negedge clk);
    check("drain_count", 32'(wlog.size()), 32'(NFILL));
    for (int i = 0; i < NFILL && i < wlog.size(); i++) begin
      e = wlog[i];
      check("drain_addr", e[63:32], a3 + 32'(4 * i));
      check("drain_data", e[31:0], sw_exp[i]);
    end
    check("drain_words", 32'(words_written), 32'(1 + N2 + NFILL));
    a3 = a3 + 32'(4 * NFILL);

    // Illegal requests: class 7, then R-type op 6
    w0 = int'(words_written);
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 16'h1, 26'h1);
    @(negedge clk);
    check("ill_cls_err", 32'(err), 32'h1);
    check("ill_cls_we", 32'(mem_we), 32'h0);
    send(3'd0, 5'd1, 5'd2, 5'd3, 3'd6, 16'h0, 26'h0);
    @(negedge clk);
    check("ill_op_err", 32'(err), 32'h1);
    check("ill_op_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    check("ill_err_clear", 32'(err), 32'h0);
    check("ill_words", 32'(words_written), 32'(w0));

    // BEQ, with a trailing NOP when delay slots are enabled
    wlog.delete();
    w0 = int'(words_written);
    send(3'd4, 5'd1, 5'd2, 5'd0, 3'd0, 16'h0003, 26'h0);
    repeat (4) @(negedge clk);
    check("beq_count", 32'(wlog.size()), 32'(NBEQ));
    if (wlog.size() >= 1) begin
      e = wlog[0]; check("beq_addr", e[63:32], a3); check("beq_data", e[31:0], 32'h10220003);
    end
`ifdef INSTR_ENC_DELAY_SLOT_EN
    if (wlog.size() >= 2) begin
      e = wlog[1]; check("nop_addr", e[63:32], a3 + 32'd4); check("nop_data", e[31:0], 32'h0);
    end
`endif
    check("beq_words", 32'(words_written), 32'(w0 + NBEQ));

    // Asynchronous reset with words queued mid-write
    @(negedge clk) mem_ack = 1'b0;
    send(3'd0, 5'd4, 5'd5, 5'd6, 3'd1, 16'h0, 26'h0);
    send(3'd0, 5'd7, 5'd8, 5'd9, 3'd2, 16'h0, 26'h0);
    send(3'd0, 5'd10, 5'd11, 5'd12, 3'd4, 16'h0, 26'h0);
    @(negedge clk);
    check("pre_rst_we", 32'(mem_we), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(mem_we), 32'h0);
    check("arst_addr", mem_addr, 32'h0);
    check("arst_wdata", mem_wdata, 32'h0);
    check("arst_words", 32'(words_written), 32'h0);
    check("arst_ready", 32'(in_ready), 32'h0);
    @(negedge clk) begin rst_n = 1'b1; mem_ack = 1'b1; end
    repeat (2) @(negedge clk);
    check("post_rst_we", 32'(mem_we), 32'h0);
    check("post_rst_words", 32'(words_written), 32'h0);
    check("post_rst_ready", 32'(in_ready), 32'h1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
